// File: rtl/m_extension_unit.sv
// Iterative RV32M multiply/divide engine: radix-2 shift-add multiply and
// restoring divide, one iteration per cycle, with early-out divide special cases.
//
// state | meaning
// IDLE  | waiting for start; operands, signs and special cases resolved here
// CALC  | one shift-add or restoring-divide step per cycle, 32 steps
// DONE  | result registered, done high for this single cycle
module m_extension_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [2:0]      op;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] opnd;
  logic [W2-1:0]   acc;
  logic [5:0]      cnt;

  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    signed_a    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    signed_b    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    sign_a      = signed_a & rs1_i[XLEN-1];
    sign_b      = signed_b & rs2_i[XLEN-1];
    mag_a       = sign_a ? -rs1_i : rs1_i;
    mag_b       = sign_b ? -rs2_i : rs2_i;
    is_div      = funct3[2];
    div_zero    = (rs2_i == '0);
    div_ovf     = !funct3[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    special     = is_div && (div_zero || div_ovf);
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? rs1_i : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : rs1_i;
  end

  // acc holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [XLEN:0]   mul_sum;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;
  logic [W2-1:0]   acc_next;
  logic [W2-1:0]   prod_final;
  logic [XLEN-1:0] q_final, r_final, calc_result;

  always_comb begin
    mul_sum = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_ge  = acc[W2-1:XLEN-1] >= {1'b0, opnd};
    div_sub = acc[W2-2:XLEN-1] - opnd;
    if (op[2])
      acc_next = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1} : {acc[W2-2:0], 1'b0};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};
    prod_final = neg_q ? -acc_next : acc_next;
    q_final    = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    r_final    = neg_r ? -acc_next[W2-1:XLEN] : acc_next[W2-1:XLEN];
    case (op)
      3'd0:             calc_result = prod_final[XLEN-1:0];
      3'd1, 3'd2, 3'd3: calc_result = prod_final[W2-1:XLEN];
      3'd4, 3'd5:       calc_result = q_final;
      default:          calc_result = r_final;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op     <= 3'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= 6'd0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            op    <= funct3;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            opnd  <= is_div ? mag_b : mag_a;
            acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt   <= 6'd0;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= calc_result;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_extension_unit.sv
// Self-checking bench for m_extension_unit: directed cases, timing, flush,
// reset and randomized ops against an arithmetic reference model.
module tb_m_extension_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  m_extension_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .rs1_i  (rs1_i),
    .rs2_i  (rs2_i),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Reference: RV32M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q;
    logic        ovf;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin q = sa / sb; r = q[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin q = sa % sb; r = q[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge in cycle c; returns at the negedge of cycle c+1.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f3;
    rs1_i  = a;
    rs2_i  = b;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    rs1_i  = $urandom;
    rs2_i  = $urandom;
  endtask

  // Samples cycles c+1 .. c+span; returns at the negedge of cycle c+span.
  task automatic observe(input int span, output int done_at, output int done_cnt,
                         output int busy_cnt, output logic [31:0] res);
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    res      = 'x;
    for (int k = 1; k <= span; k++) begin
      if (k > 1) @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          res     = result;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    rs1_i  = '0;
    rs2_i  = '0;
    #12;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_timing();
    logic [31:0] exp_res;
    exp_res = model(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      n_checks++;
      if (busy !== (k <= 32)) begin
        n_fail++; $display("FAIL mul_busy c+%0d: got %b expected %b", k, busy, (k <= 32));
      end
      n_checks++;
      if (done !== (k == 33)) begin
        n_fail++; $display("FAIL mul_done c+%0d: got %b expected %b", k, done, (k == 33));
      end
      if (k == 33) begin
        n_checks++;
        if (result !== exp_res) begin
          n_fail++; $display("FAIL mul_result: got %h expected %h", result, exp_res);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [10] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] as  [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exs [10] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int lat [10] = '{33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    int d_at, d_cnt, b_cnt;
    logic [31:0] res;
    for (int i = 0; i < 10; i++) begin
      issue(f3s[i], as[i], bs[i]);
      observe(lat[i] + 1, d_at, d_cnt, b_cnt, res);
      n_checks++;
      if (res !== exs[i]) begin
        n_fail++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, exs[i]);
      end
      n_checks++;
      if (d_at !== lat[i] || d_cnt !== 1) begin
        n_fail++; $display("FAIL directed_%0d_done: got cycle %0d count %0d expected cycle %0d count 1", i, d_at, d_cnt, lat[i]);
      end
      n_checks++;
      if (b_cnt !== ((lat[i] == 33) ? 32 : 0)) begin
        n_fail++; $display("FAIL directed_%0d_busy: got %0d cycles expected %0d", i, b_cnt, (lat[i] == 33) ? 32 : 0);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, exp_res;
    int d_at, d_cnt, b_cnt;
    logic [31:0] res;
    prev = result;
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got busy %b done %b expected 0 0", busy, done);
    end
    n_checks++;
    if (result !== prev) begin
      n_fail++; $display("FAIL flush_result_held: got %h expected %h", result, prev);
    end
    exp_res = model(3'd7, 32'd1000, 32'd33);
    issue(3'd7, 32'd1000, 32'd33);
    observe(36, d_at, d_cnt, b_cnt, res);
    n_checks++;
    if (d_at !== 33 || d_cnt !== 1 || res !== exp_res) begin
      n_fail++; $display("FAIL flush_restart: got cycle %0d count %0d result %h expected cycle 33 count 1 result %h", d_at, d_cnt, res, exp_res);
    end
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = 3'd0;
    rs1_i  = 32'd3;
    rs2_i  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    observe(3, d_at, d_cnt, b_cnt, res);
    n_checks++;
    if (b_cnt !== 0 || d_cnt !== 0) begin
      n_fail++; $display("FAIL flush_blocks_start: got busy %0d done %0d expected 0 0", b_cnt, d_cnt);
    end
  endtask

  task automatic test_start_held();
    int d_cnt, first_at, second_at;
    start  = 1'b1;
    funct3 = 3'd0;
    rs1_i  = 32'd9;
    rs2_i  = 32'd11;
    d_cnt = 0; first_at = -1; second_at = -1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d_cnt++;
        if (first_at < 0) first_at = k;
        else if (second_at < 0) second_at = k;
      end
    end
    start = 1'b0;
    n_checks++;
    if (d_cnt !== 2 || first_at !== 33 || second_at !== 67) begin
      n_fail++; $display("FAIL start_held: got %0d pulses at %0d,%0d expected 2 at 33,67", d_cnt, first_at, second_at);
    end
    repeat (35) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d_at, d_cnt, b_cnt;
    logic [31:0] res, exp_res;
    issue(3'd5, 32'd5, 32'd0);
    observe(1, d_at, d_cnt, b_cnt, res);
    n_checks++;
    if (d_at !== 1 || res !== 32'hFFFF_FFFF || b_cnt !== 0) begin
      n_fail++; $display("FAIL b2b_special: got cycle %0d result %h busy %0d expected cycle 1 result ffffffff busy 0", d_at, res, b_cnt);
    end
    @(negedge clk);
    exp_res = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    observe(33, d_at, d_cnt, b_cnt, res);
    n_checks++;
    if (d_at !== 33 || res !== exp_res) begin
      n_fail++; $display("FAIL b2b_second: got cycle %0d result %h expected cycle 33 result %h", d_at, res, exp_res);
    end
    @(negedge clk);
    exp_res = model(3'd6, 32'hDEAD_BEEF, 32'd1234);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1234);
    observe(34, d_at, d_cnt, b_cnt, res);
    n_checks++;
    if (d_at !== 33 || d_cnt !== 1 || res !== exp_res) begin
      n_fail++; $display("FAIL b2b_third: got cycle %0d result %h expected cycle 33 result %h", d_at, res, exp_res);
    end
  endtask

  task automatic test_reset_mid();
    int d_at, d_cnt, b_cnt;
    logic [31:0] res;
    issue(3'd0, $urandom, $urandom);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: got busy %b done %b result %h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    observe(40, d_at, d_cnt, b_cnt, res);
    n_checks++;
    if (d_cnt !== 0 || b_cnt !== 0) begin
      n_fail++; $display("FAIL reset_abort: got done %0d busy %0d expected 0 0", d_cnt, b_cnt);
    end
    @(negedge clk);
    issue(3'd0, 32'd3, 32'd4);
    observe(34, d_at, d_cnt, b_cnt, res);
    n_checks++;
    if (d_at !== 33 || d_cnt !== 1 || res !== 32'd12) begin
      n_fail++; $display("FAIL reset_recover: got cycle %0d count %0d result %h expected cycle 33 count 1 result 0000000c", d_at, d_cnt, res);
    end
  endtask

  task automatic test_random();
    int d_at, d_cnt, b_cnt, exp_lat;
    logic [2:0]  f3;
    logic [31:0] a, b, res, exp_res;
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      exp_res = model(f3, a, b);
      exp_lat = is_special(f3, a, b) ? 1 : 33;
      issue(f3, a, b);
      observe(36, d_at, d_cnt, b_cnt, res);
      n_checks++;
      if (res !== exp_res || d_at !== exp_lat || d_cnt !== 1 || b_cnt !== ((exp_lat == 33) ? 32 : 0)) begin
        n_fail++;
        $display("FAIL random_%0d op %0d a %h b %h: got result %h cycle %0d count %0d busy %0d expected result %h cycle %0d count 1 busy %0d",
                 i, f3, a, b, res, d_at, d_cnt, b_cnt, exp_res, exp_lat, (exp_lat == 33) ? 32 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_directed();
    test_flush();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
